// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
//   Shared definitions for the system ID checker: FSM state encoding, the
//   word addresses of the sysid slave, and the default build-time values.
// -----------------------------------------------------------------------------
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    RETRY = 3'd3,
    CHECK = 3'd4,
    FAIL  = 3'd5,
    DONE  = 3'd6
  } sysid_state_t;

  localparam logic        SYSID_ADDR_ID       = 1'b0;
  localparam logic        SYSID_ADDR_TS       = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1720163545;

  // True for the two states that own an outstanding read strobe.
  function automatic logic is_read_state(input sysid_state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/sysid_timeout_ctr.sv
// -----------------------------------------------------------------------------
// sysid_timeout_ctr
//   16-bit saturating stall counter. Counts cycles with inc=1, returns to zero
//   on clear (clear has priority over inc).
// Ports:
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   clear    in   zero the counter this edge
//   inc      in   count one stalled cycle
//   count    out  current count
// -----------------------------------------------------------------------------
module sysid_timeout_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/system_0_sysid_checker.sv
// -----------------------------------------------------------------------------
// system_0_sysid_checker
//   Avalon-MM read master for the system ID slave. Reads the ID word (addr 0)
//   then the timestamp word (addr 1), compares both with build-time values and
//   reports pass / mismatch / timeout to the boot controller.
//
// Handshake: avm_read/avm_address act as valid and are registered; the slave
//   accepts with !avm_waitrequest. A transfer happens on the cycle where
//   avm_read && !avm_waitrequest, and avm_readdata is valid on that cycle only.
//   While waitrequest is high the request is held unchanged, unless the stall
//   budget runs out, in which case the read strobe is withdrawn.
//
// Ports:
//   clock, reset_n      clock and synchronous active-low reset
//   start               1-cycle launch pulse (accepted in IDLE or DONE)
//   avm_address/read    registered read request to the sysid slave
//   avm_waitrequest     slave stall
//   avm_readdata        read data
//   busy                sequence in progress (RD_ID, RD_TS, RETRY, CHECK)
//   done/pass           sticky outcome flags
//   id_mismatch         sticky; ID word differed
//   ts_mismatch         sticky; timestamp word differed
//   timeout             sticky; retries exhausted on a stalled read
//   read_id/read_ts     captured words
//   fsm_state           current FSM state (debug)
// -----------------------------------------------------------------------------
module system_0_sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic [2:0]  fsm_state
);

  localparam logic [15:0] STALL_LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT    = 3'(MAX_RETRIES);

  sysid_state_t state, state_next;

  logic        auto_pend;   // one-shot launch request armed by reset
  logic [2:0]  retries;
  logic [15:0] stall_cnt;

  logic xfer;
  logic stall;
  logic stall_expired;
  logic launch;
  logic retry_ok;

  assign xfer          = avm_read && !avm_waitrequest;
  assign stall         = avm_read && avm_waitrequest;
  // The cycle that would bring the count to TIMEOUT_CYCLES ends the attempt.
  assign stall_expired = stall && (stall_cnt == STALL_LIMIT_M1);
  assign retry_ok      = (retries < RETRY_LIMIT);

  // Counter restarts on every transfer and whenever no read is outstanding,
  // so each attempt and each word gets a fresh stall budget.
  sysid_timeout_ctr u_timeout_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (xfer || !avm_read),
    .inc     (stall),
    .count   (stall_cnt)
  );

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          state_next = RD_ID;
          launch     = 1'b1;
        end
      end
      RD_ID: begin
        if (xfer)               state_next = RD_TS;
        else if (stall_expired) state_next = RETRY;
      end
      RD_TS: begin
        if (xfer)               state_next = CHECK;
        else if (stall_expired) state_next = RETRY;
      end
      RETRY: state_next = retry_ok ? RD_ID : FAIL;
      CHECK: state_next = DONE;
      FAIL:  state_next = DONE;
      DONE: begin
        if (start) begin
          state_next = RD_ID;
          launch     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      retries     <= 3'd0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= 32'd0;
      read_ts     <= 32'd0;
    end else begin
      state       <= state_next;
      // Request outputs follow the next state so they are registered.
      avm_read    <= is_read_state(state_next);
      avm_address <= (state_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

      if (launch) begin
        auto_pend   <= 1'b0;
        retries     <= 3'd0;
        done        <= 1'b0;
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end

      if ((state == RD_ID) && xfer) read_id <= avm_readdata;
      if ((state == RD_TS) && xfer) read_ts <= avm_readdata;

      if ((state == RETRY) && retry_ok) retries <= retries + 3'd1;

      if (state == CHECK) begin
        id_mismatch <= (read_id != EXPECTED_ID);
        ts_mismatch <= (read_ts != EXPECTED_TS);
        pass        <= (read_id == EXPECTED_ID) && (read_ts == EXPECTED_TS);
        done        <= 1'b1;
      end

      if (state == FAIL) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

  assign busy      = (state == RD_ID) || (state == RD_TS) ||
                     (state == RETRY) || (state == CHECK);
  assign fsm_state = state;

endmodule
